// File: rtl/imm_extend_pipe.sv
// Immediate extender with a one-cycle valid/ready output stage.
// Optional one-entry skid buffer enabled by defining IMM_EXT_SKID_EN.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   // state | meaning
   // EMPTY | nothing held
   // ONE   | output register valid
   // TWO   | output register plus skid entry valid (skid build only)
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } state_t;

   state_t           state, state_nxt;
   logic [OUT_W-1:0] out_reg, out_nxt;
   logic [OUT_W-1:0] ext_res;
   logic [OUT_W-1:0] sext;
   logic             accept, take;

   assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

   always_comb begin
      ext_res = '0;
      case (in_mode)
         2'b00:   ext_res = {{(OUT_W-IN_W){1'b0}}, in_imm};
         2'b01:   ext_res = sext;
         2'b10:   ext_res = {in_imm, {(OUT_W-IN_W){1'b0}}};
         default: ext_res = sext << 2;
      endcase
   end

   assign out_valid = (state != EMPTY);
   assign out_data  = out_valid ? out_reg : '0;
   assign take      = out_valid && out_ready;
   assign accept    = in_valid && in_ready;

`ifdef IMM_EXT_SKID_EN
   logic [OUT_W-1:0] skid_reg, skid_nxt;

   // Depends only on the state register, so out_ready never reaches in_ready.
   assign in_ready = (state != TWO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) skid_reg <= '0;
      else       skid_reg <= skid_nxt;
   end
`else
   assign in_ready = !out_valid || out_ready;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         out_reg <= '0;
      end else begin
         state   <= state_nxt;
         out_reg <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_nxt   = out_reg;
`ifdef IMM_EXT_SKID_EN
      skid_nxt  = skid_reg;
`endif
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               out_nxt   = ext_res;
            end
         end
         ONE: begin
            if (accept && take) begin
               out_nxt = ext_res;
            end else if (take) begin
               state_nxt = EMPTY;
               out_nxt   = '0;
            end else if (accept) begin
`ifdef IMM_EXT_SKID_EN
               state_nxt = TWO;
               skid_nxt  = ext_res;
`else
               state_nxt = ONE;
`endif
            end
         end
         TWO: begin
`ifdef IMM_EXT_SKID_EN
            if (take) begin
               state_nxt = ONE;
               out_nxt   = skid_reg;
               skid_nxt  = '0;
            end
`else
            state_nxt = EMPTY;
            out_nxt   = '0;
`endif
         end
         default: begin
            state_nxt = EMPTY;
            out_nxt   = '0;
         end
      endcase

      if (flush) begin
         state_nxt = EMPTY;
         out_nxt   = '0;
`ifdef IMM_EXT_SKID_EN
         skid_nxt  = '0;
`endif
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16/32 instance plus a 12/20 instance.
// Skid-buffer sequences are selected by IMM_EXT_SKID_EN.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [31:0] out_data;

   logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [11:0] s_in_imm;
   logic [1:0]  s_in_mode;
   logic [19:0] s_out_data;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   imm_extend_pipe #(.IN_W(12), .OUT_W(20)) u_small (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_imm(s_in_imm), .in_mode(s_in_mode), .flush(s_flush), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] imm, input logic [1:0] mode);
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 0; in_imm = '0; in_mode = '0; flush = 0; out_ready = 0;
      s_in_valid = 0; s_in_imm = '0; s_in_mode = '0; s_flush = 0; s_out_ready = 0;
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // sign-extend, then back-to-back modes with out_ready held high
      out_ready = 1'b1;
      offer(16'h8001, 2'b01);
      s_in_valid = 1'b1; s_in_imm = 12'hFFF; s_in_mode = 2'b11; s_out_ready = 1'b1;
      tick();
      chk("sext_valid", {31'd0, out_valid}, 32'd1);
      chk("sext_data", out_data, 32'hFFFF8001);
      chk("small_br", {12'd0, s_out_data}, 32'h000FFFFC);
      s_in_valid = 1'b0;
      offer(16'h8001, 2'b00); tick();
      chk("zext_data", out_data, 32'h00008001);
      offer(16'h8001, 2'b10); tick();
      chk("lui_data", out_data, 32'h80010000);
      chk("small_drain", {31'd0, s_out_valid}, 32'd0);
      offer(16'h8001, 2'b11); tick();
      chk("br_neg", out_data, 32'hFFFE0004);
      offer(16'h7FFF, 2'b01); tick();
      chk("sext_pos", out_data, 32'h00007FFF);
      offer(16'h7FFF, 2'b11); tick();
      chk("br_pos", out_data, 32'h0001FFFC);
      in_valid = 1'b0; tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_data", out_data, 32'd0);

      // back-pressure
      out_ready = 1'b0;
      offer(16'h0001, 2'b00); tick();
      chk("bp_first", out_data, 32'h1);
`ifdef IMM_EXT_SKID_EN
      offer(16'h0002, 2'b00); #1;
      chk("bp_ready1", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_hold1", out_data, 32'h1);
      chk("bp_full", {31'd0, in_ready}, 32'd0);
      offer(16'h0003, 2'b00); tick();
      chk("bp_hold2", out_data, 32'h1);
      chk("bp_full2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; tick();
      chk("bp_second", out_data, 32'h2);
      chk("bp_ready2", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_third", out_data, 32'h3);
      in_valid = 1'b0; tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);
`else
      offer(16'h0002, 2'b00); #1;
      chk("bp_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold", out_data, 32'h1);
      chk("bp_stall2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; #1;
      chk("bp_comb_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_second", out_data, 32'h2);
      in_valid = 1'b0; tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);
`endif

      // flush while holding, with a simultaneous offer
      out_ready = 1'b0;
      offer(16'h0005, 2'b00); tick();
      chk("fl_held", out_data, 32'h5);
`ifdef IMM_EXT_SKID_EN
      offer(16'h0006, 2'b00); tick();
      chk("fl_two", {31'd0, in_ready}, 32'd0);
`endif
      offer(16'h0007, 2'b00); flush = 1'b1; tick();
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_data", out_data, 32'd0);
      chk("fl_ready", {31'd0, in_ready}, 32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("fl_discard", {31'd0, out_valid}, 32'd0);

      // asynchronous reset between edges
      out_ready = 1'b0;
      offer(16'h0009, 2'b00); tick();
      chk("ar_before", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_data", out_data, 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("ar_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("ar_stay", {31'd0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
